// File: rtl/ram_arbiter_if.sv
// Requester-side handshake bundle for ram_arbiter.
// Port 0 is the CPU load/store unit and port 1 the debug/DMA loader.
interface ram_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [15:0] rdata;
    logic        err;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, done0, done1, rdata, err
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, done0, done1, rdata, err
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and single-cycle access sequencer for the
// 16-bit data RAM: accept, one-cycle RAM access, one-cycle completion pulse.
module ram_arbiter #(
    parameter logic [15:0] ADDR_MAX = 16'd14
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus,
    output logic          ram_cs,
    output logic          ram_rw_,
    output logic [15:0]   ram_addr,
    output logic [15:0]   ram_wdata,
    input  logic [15:0]   ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic        prio;
    logic        owner;
    logic        done0_q;
    logic        done1_q;
    logic        err_q;
    logic [15:0] rdata_q;

    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;

    // Grant is combinational so the requester sees it in the accept cycle;
    // gating with rst_n keeps both grants low throughout reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an unassigned path infers a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state == IDLE) begin
            if (bus.req0 && (!bus.req1 || !prio)) begin
                gnt0 = 1'b1;
            end else if (bus.req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign accept    = gnt0 | gnt1;
    assign sel_we    = gnt1 ? bus.we1    : bus.we0;
    assign sel_addr  = gnt1 ? bus.addr1  : bus.addr0;
    assign sel_wdata = gnt1 ? bus.wdata1 : bus.wdata0;

    assign bus.gnt0  = gnt0;
    assign bus.gnt1  = gnt1;
    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

    // The RAM bus registers double as the latched request fields: they are
    // loaded on accept and are only non-idle while in ACCESS, so an async
    // reset drops ram_cs immediately.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            owner     <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 16'h0000;
            ram_cs    <= 1'b0;
            ram_rw_   <= 1'b1;
            ram_addr  <= 16'h0000;
            ram_wdata <= 16'h0000;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= gnt1;
                        prio  <= ~gnt1;
                        if (sel_addr <= ADDR_MAX) begin
                            state     <= ACCESS;
                            ram_cs    <= 1'b1;
                            ram_rw_   <= ~sel_we;
                            ram_addr  <= sel_addr;
                            ram_wdata <= sel_wdata;
                        end else begin
                            // Out-of-range word: skip the RAM entirely.
                            state   <= RESP;
                            err_q   <= 1'b1;
                            rdata_q <= 16'h0000;
                            done0_q <= ~gnt1;
                            done1_q <= gnt1;
                        end
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    if (ram_rw_) begin
                        rdata_q <= ram_rdata;
                    end
                    err_q     <= 1'b0;
                    done0_q   <= ~owner;
                    done1_q   <= owner;
                    ram_cs    <= 1'b0;
                    ram_rw_   <= 1'b1;
                    ram_addr  <= 16'h0000;
                    ram_wdata <= 16'h0000;
                end
                RESP: begin
                    state <= IDLE;
                    err_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 16-byte big-endian RAM model.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ram_cs;
    logic        ram_rw_;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic [7:0]  mem [16];
    logic [3:0]  a_hi;
    logic [3:0]  a_lo;

    int passed = 0;
    int total  = 0;

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .ram_cs    (ram_cs),
        .ram_rw_   (ram_rw_),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0xDEAD stands in for the floating bus when the RAM is not read-selected.
    assign a_hi = ram_addr[3:0];
    assign a_lo = ram_addr[3:0] + 4'd1;
    assign ram_rdata = (ram_cs && ram_rw_) ? {mem[a_hi], mem[a_lo]} : 16'hDEAD;

    always @(posedge clk) begin
        if (ram_cs && !ram_rw_) begin
            mem[a_hi] <= ram_wdata[15:8];
            mem[a_lo] <= ram_wdata[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input bit port, input bit req, input bit we,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (port) begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
    endtask

    // Single uncontested access with full timeline checks.
    task automatic do_access(input bit port, input bit we, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [15:0] exp_rdata);
        bit bad;
        bad = (addr > 16'd14);
        @(negedge clk);
        drive(port, 1'b1, we, addr, wdata);
        #1;
        check("acc_gnt0", bus.gnt0, !port);
        check("acc_gnt1", bus.gnt1, port);
        @(negedge clk);
        drive(port, 1'b0, we, addr, wdata);
        if (!bad) begin
            check("acc_cs", ram_cs, 1'b1);
            check("acc_rw", ram_rw_, !we);
            check("acc_addr", ram_addr, addr);
            check("acc_wdata", ram_wdata, wdata);
            check("acc_nognt", bus.gnt0 | bus.gnt1, 1'b0);
            check("acc_nodone", bus.done0 | bus.done1, 1'b0);
            @(negedge clk);
        end
        check("resp_done0", bus.done0, !port);
        check("resp_done1", bus.done1, port);
        check("resp_err", bus.err, bad);
        check("resp_rdata", bus.rdata, exp_rdata);
        check("resp_cs", ram_cs, 1'b0);
        @(negedge clk);
        check("idle_done", bus.done0 | bus.done1, 1'b0);
        check("idle_err", bus.err, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[2] = 8'h11; mem[3] = 8'h22;
        mem[6] = 8'h33; mem[7] = 8'h44;

        // Reset: requests present but no grant, all outputs at reset values.
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 16'd2, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 16'd6, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("rst_gnt0", bus.gnt0, 1'b0);
        check("rst_gnt1", bus.gnt1, 1'b0);
        check("rst_cs", ram_cs, 1'b0);
        check("rst_rw", ram_rw_, 1'b1);
        check("rst_addr", ram_addr, 16'h0000);
        check("rst_wdata", ram_wdata, 16'h0000);
        check("rst_rdata", bus.rdata, 16'h0000);
        check("rst_err", bus.err, 1'b0);
        check("rst_done", {bus.done1, bus.done0}, 2'b00);

        // Both ports held from reset: grants 0,1,0,1 with done every 3 cycles.
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            check("rr_gnt0", bus.gnt0, (c % 3 == 0) && ((c / 3) % 2 == 0));
            check("rr_gnt1", bus.gnt1, (c % 3 == 0) && ((c / 3) % 2 == 1));
            check("rr_done0", bus.done0, (c % 3 == 2) && ((c / 3) % 2 == 0));
            check("rr_done1", bus.done1, (c % 3 == 2) && ((c / 3) % 2 == 1));
            if (c % 3 == 2) begin
                check("rr_rdata", bus.rdata, ((c / 3) % 2 == 0) ? 16'h1122 : 16'h3344);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 16'd0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'd0, 16'h0000);

        // Single write then read on port 0; rdata holds through the write.
        do_access(1'b0, 1'b1, 16'd4, 16'hA55A, 16'h3344);
        do_access(1'b0, 1'b0, 16'd4, 16'h0000, 16'hA55A);

        // Boundary addresses.
        do_access(1'b0, 1'b1, 16'd14, 16'h1234, 16'hA55A);
        do_access(1'b0, 1'b0, 16'd14, 16'h0000, 16'h1234);
        do_access(1'b0, 1'b0, 16'd15, 16'h0000, 16'h0000);
        do_access(1'b1, 1'b1, 16'h0104, 16'h7777, 16'h0000);
        check("alias_mem4", {mem[4], mem[5]}, 16'hA55A);
        do_access(1'b0, 1'b0, 16'd2, 16'h0000, 16'h1122);

        // Port 1 writes while port 0 waits (prio points at port 1), then port 0 reads it back.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 16'd8, 16'h0000);
        drive(1'b1, 1'b1, 1'b1, 16'd8, 16'hBEEF);
        #1;
        check("il_gnt1", bus.gnt1, 1'b1);
        check("il_gnt0", bus.gnt0, 1'b0);
        @(negedge clk);
        check("il_rw", ram_rw_, 1'b0);
        check("il_wdata", ram_wdata, 16'hBEEF);
        check("il_wait_gnt0", bus.gnt0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 16'd0, 16'h0000);
        check("il_done1", bus.done1, 1'b1);
        check("il_hold_rdata", bus.rdata, 16'h1122);
        @(negedge clk);
        #1;
        check("il_gnt0_next", bus.gnt0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'd0, 16'h0000);
        @(negedge clk);
        check("il_done0", bus.done0, 1'b1);
        check("il_rdata", bus.rdata, 16'hBEEF);

        // Reset during the ACCESS cycle of a port 0 write (prio now points at port 1).
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 16'd10, 16'h5555);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'd0, 16'h0000);
        check("mr_cs_before", ram_cs, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_cs_async", ram_cs, 1'b0);
        check("mr_rw_async", ram_rw_, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 16'd6, 16'h0000);
        #1;
        check("mr_gnt1_in_rst", bus.gnt1, 1'b0);
        @(negedge clk);
        check("mr_no_done", {bus.done1, bus.done0}, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 16'd0, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_rdata", bus.rdata, 16'h0000);
        check("mr_err", bus.err, 1'b0);
        check("mr_addr", ram_addr, 16'h0000);
        check("mr_done", {bus.done1, bus.done0}, 2'b00);
        drive(1'b0, 1'b1, 1'b0, 16'd2, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 16'd6, 16'h0000);
        #1;
        check("mr_first_gnt0", bus.gnt0, 1'b1);
        check("mr_first_gnt1", bus.gnt1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'd0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'd0, 16'h0000);
        @(negedge clk);
        check("mr_done0", bus.done0, 1'b1);
        check("mr_rd", bus.rdata, 16'h1122);

        // Idle bus over 20 cycles.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_cs", ram_cs, 1'b0);
            check("idle_rw", ram_rw_, 1'b1);
            check("idle_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and access sequencer for the 16-bit data RAM. Port 0 is the CPU load/store unit and port 1 the debug/DMA loader. The block accepts one request at a time and drives the RAM's chip-select, read/write, address and write-data lines for exactly one cycle. It captures read data, then returns a one-cycle completion pulse to the owning requester. It also rejects word addresses that would run past the 16-byte array.

## Interface
- ADDR_MAX, 14: highest legal word address. A word access touches bytes addr and addr+1, so addr must be ≤ ADDR_MAX; the full 16 bits are compared.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request from port 0 / 1; level, with its fields held stable while high
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  16  byte address of big-endian word
- wdata0 / wdata1  in  16  write data
- gnt0 / gnt1  out  1  combinational accept; the transfer occurs in the cycle with req_i && gnt_i
- done0 / done1  out  1  one-cycle completion pulse for port i
- rdata  out  16  read result, valid while done_i=1 for a read
- err  out  1  valid with done_i; 1 = address out of range, no RAM access performed
- ram_cs  out  1  RAM chip select
- ram_rw_  out  1  1 = read, 0 = write (RAM convention)
- ram_addr  out  16  RAM address
- ram_wdata  out  16  RAM write data
- ram_rdata  in  16  RAM combinational read data; high-Z when not selected

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - gnt goes to at most one port.
  - If only one req is high, that port is granted.
  - If both are high, the port equal to the priority pointer `prio` is granted.
  - On accept, latch we, addr and wdata, plus `owner`, and set prio = the other port.
  - Next state: ACCESS if latched addr ≤ ADDR_MAX, else RESP with err_q=1.
- ACCESS:
  - ram_cs=1, ram_rw_=~we_q, ram_addr=addr_q, ram_wdata=wdata_q.
  - For a read, capture ram_rdata into rdata at the closing edge.
  - A write commits in the RAM at that same edge.
  - Next state: RESP.
- RESP:
  - done[owner]=1 and err=err_q. Next state: IDLE.
  - gnt is 0 in ACCESS and RESP; no request is accepted there.
- ram_cs is 0 in every state except ACCESS.
  - ram_rw_=1, ram_addr=0, ram_wdata=0 when not in ACCESS.
  - The bus is therefore never in write mode while idle.
- rdata update rules:
  - Updated only by a valid read; holds through writes.
  - Set to 0 on an err response.
- Priority pointer:
  - `prio` changes only on accept; reset value 0.
  - A single requester may be granted back-to-back; it does not wait for the other port.

## Timing
- Acceptance to done: accept at cycle N (IDLE), ACCESS at N+1, done at N+2. Next accept is possible at N+3.
- Sustained throughput: 1 access per 3 cycles.
- Erroneous access: accept at N, done+err at N+1, no ram_cs pulse.
- A requester holding req high after its done is re-arbitrated in the following IDLE cycle.
- Reset values: state=IDLE, prio=0, owner=0, rdata=0, err=0, done0=done1=0, ram_cs=0, ram_rw_=1, ram_addr=0, ram_wdata=0.
  - gnt0=gnt1=0 while rst_n=0, regardless of req.
- Reset asserted in ACCESS: ram_cs drops immediately (asynchronous). The write is not guaranteed and no done is issued.
- Reset asserted in RESP: the done pulse is truncated.
- Simultaneous req0 and req1 from reset: port 0 is granted first, then port 1, then alternating while both are held.
- Request rising in ACCESS/RESP: not acknowledged until the next IDLE. Its fields must stay stable until gnt.

## Test plan
- Single write then read, port 0:
  - Write addr=4, wdata=0xA55A.
  - Expect ram_cs=1, ram_rw_=0, ram_addr=4 for exactly one cycle, done0 2 cycles after accept, err=0.
  - Read addr=4 → rdata=0xA55A with done0.
- Both ports hold req continuously, each reading a distinct preloaded address:
  - Grants alternate 0,1,0,1.
  - done pulses are spaced 3 cycles apart.
  - Each rdata matches its owner's address.
- Boundary addresses:
  - addr=14 write 0x1234, then read → 0x1234, err=0.
  - addr=15 → done with err=1, rdata=0, no ram_cs pulse.
  - addr=0x0104 → err=1 (upper bits rejected, no aliasing).
- Write/read interleave across ports:
  - Port 1 writes 0xBEEF at addr=8 while port 0 waits; port 0 then reads addr=8 → 0xBEEF.
  - rdata keeps its previous read value during port 1's done.
- Reset mid-operation:
  - Drop rst_n during ACCESS of a write → ram_cs=0 in the same cycle, no done.
  - After release, all outputs are at reset values and port 0 wins the first contested grant.
- Idle bus check: with no requests over 20 cycles, ram_cs=0, ram_rw_=1, gnt0=gnt1=0 throughout.
